// File: rtl/addsub_pipe.sv
// Pipelined add/subtract unit: the N_BIT operation is split into N_STAGES carry-chained
// segments, one per stage, with valid/ready flow control, status flags and optional saturation.
module addsub_pipe #(
  parameter int N_BIT    = 32,
  parameter int N_BPB    = 4,
  parameter int N_STAGES = 4,
  parameter bit SAT_EN   = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_BIT-1:0] in_a,
  input  logic [N_BIT-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_BIT-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int W     = N_BIT / N_STAGES;
  localparam int N_BLK = W / N_BPB;
  localparam int MSB   = N_BIT - 1;
  localparam logic [N_BPB:0] ONE_BLK = (N_BPB + 1)'(1);

  // Carry-select segment adder: each block precomputes both carry-in cases and
  // the incoming carry only drives the block muxes.
  function automatic logic [W:0] seg_add(input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic         cin);
    logic [N_BPB:0] r0;
    logic [N_BPB:0] r1;
    logic [W-1:0]   s;
    logic           c;
    c = cin;
    s = '0;
    for (int j = 0; j < N_BLK; j++) begin
      r0 = {1'b0, a[j*N_BPB +: N_BPB]} + {1'b0, b[j*N_BPB +: N_BPB]};
      r1 = {1'b0, a[j*N_BPB +: N_BPB]} + {1'b0, b[j*N_BPB +: N_BPB]} + ONE_BLK;
      s[j*N_BPB +: N_BPB] = c ? r1[N_BPB-1:0] : r0[N_BPB-1:0];
      c = c ? r1[N_BPB] : r0[N_BPB];
    end
    return {c, s};
  endfunction

  // Values entering stage k: operands, partial sum so far, carry and valid.
  logic [N_BIT-1:0]    a_c [N_STAGES];
  logic [N_BIT-1:0]    b_c [N_STAGES];
  logic [N_BIT-1:0]    s_c [N_STAGES];
  logic [N_STAGES-1:0] c_c;
  logic [N_STAGES-1:0] v_c;
  logic [N_STAGES-1:0] ld;

  assign a_c[0]   = in_a;
  assign b_c[0]   = in_op ? ~in_b : in_b;
  assign s_c[0]   = '0;
  assign c_c[0]   = in_cin;
  assign v_c[0]   = in_valid;
  assign in_ready = rst_n && ld[0];

  for (genvar k = 0; k < N_STAGES; k++) begin : g_stage
    logic [W:0]       seg;
    logic [N_BIT-1:0] s_n;

    assign seg = seg_add(a_c[k][k*W +: W], b_c[k][k*W +: W], c_c[k]);

    // NOTE: s_n takes a full default before the segment overwrite, so no latch is inferred.
    always_comb begin
      s_n            = s_c[k];
      s_n[k*W +: W]  = seg[W-1:0];
    end

    if (k < N_STAGES - 1) begin : g_mid
      logic             v_q;
      logic             c_q;
      logic [N_BIT-1:0] a_q;
      logic [N_BIT-1:0] b_q;
      logic [N_BIT-1:0] s_q;

      // A stage loads when empty or when its contents move on, so bubbles collapse.
      assign ld[k] = !v_q || ld[k+1];

      // NOTE: state updates use non-blocking assignments so every stage samples pre-edge values.
      always_ff @(posedge clk) begin
        if (!rst_n)     v_q <= 1'b0;
        else if (ld[k]) v_q <= v_c[k];
      end

      // NOTE: datapath registers have no reset; they load only with a valid beat,
      // so stale contents never reach the outputs.
      always_ff @(posedge clk) begin
        if (ld[k] && v_c[k]) begin
          a_q <= a_c[k];
          b_q <= b_c[k];
          s_q <= s_n;
          c_q <= seg[W];
        end
      end

      assign v_c[k+1] = v_q;
      assign a_c[k+1] = a_q;
      assign b_c[k+1] = b_q;
      assign s_c[k+1] = s_q;
      assign c_c[k+1] = c_q;
    end else begin : g_last
      logic             ovf;
      logic [N_BIT-1:0] sat_val;
      logic [N_BIT-1:0] res;

      assign ld[k]   = !out_valid || out_ready;
      assign ovf     = (a_c[k][MSB] == b_c[k][MSB]) && (s_n[MSB] != a_c[k][MSB]);
      assign sat_val = a_c[k][MSB] ? {1'b1, {MSB{1'b0}}} : {1'b0, {MSB{1'b1}}};
      assign res     = (SAT_EN && ovf) ? sat_val : s_n;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          out_valid <= 1'b0;
          out_sum   <= '0;
          out_cout  <= 1'b0;
          out_ovf   <= 1'b0;
          out_zero  <= 1'b0;
        end else if (ld[k]) begin
          out_valid <= v_c[k];
          if (v_c[k]) begin
            out_sum  <= res;
            out_cout <= seg[W];
            out_ovf  <= ovf;
            out_zero <= (res == '0);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_addsub_pipe.sv
// Bench for addsub_pipe: directed checks on the default 4-stage unit (wrap and saturate),
// then randomized traffic on four configurations against an arithmetic reference model.
module tb_addsub_pipe;

  localparam int ND = 4;
  localparam int NB = 10000;
  localparam logic [ND-1:0] SAT_MASK = 4'b0110;

  logic        clk;
  logic        rst_n;
  logic        in_valid  [ND];
  logic        in_ready  [ND];
  logic [31:0] in_a      [ND];
  logic [31:0] in_b      [ND];
  logic        in_cin    [ND];
  logic        in_op     [ND];
  logic        out_valid [ND];
  logic        out_ready [ND];
  logic [31:0] out_sum   [ND];
  logic        out_cout  [ND];
  logic        out_ovf   [ND];
  logic        out_zero  [ND];

  int n_cmp = 0;
  int n_err = 0;

  logic [34:0] exp_q    [ND][$];
  logic        held     [ND];
  logic [34:0] held_val [ND];

  int          lat, bi, ng, n_out, cyc;
  logic [31:0] got  [8];
  int          gcyc [8];
  int          cnt  [ND];
  bit          took [ND];

  addsub_pipe #(.N_BIT(32), .N_BPB(4), .N_STAGES(4), .SAT_EN(1'b0)) u_d0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_a(in_a[0]), .in_b(in_b[0]), .in_cin(in_cin[0]), .in_op(in_op[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_sum(out_sum[0]),
    .out_cout(out_cout[0]), .out_ovf(out_ovf[0]), .out_zero(out_zero[0]));

  addsub_pipe #(.N_BIT(32), .N_BPB(4), .N_STAGES(4), .SAT_EN(1'b1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_a(in_a[1]), .in_b(in_b[1]), .in_cin(in_cin[1]), .in_op(in_op[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_sum(out_sum[1]),
    .out_cout(out_cout[1]), .out_ovf(out_ovf[1]), .out_zero(out_zero[1]));

  addsub_pipe #(.N_BIT(32), .N_BPB(4), .N_STAGES(1), .SAT_EN(1'b1)) u_d2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_a(in_a[2]), .in_b(in_b[2]), .in_cin(in_cin[2]), .in_op(in_op[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_sum(out_sum[2]),
    .out_cout(out_cout[2]), .out_ovf(out_ovf[2]), .out_zero(out_zero[2]));

  addsub_pipe #(.N_BIT(32), .N_BPB(1), .N_STAGES(32), .SAT_EN(1'b0)) u_d3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
    .in_a(in_a[3]), .in_b(in_b[3]), .in_cin(in_cin[3]), .in_op(in_op[3]),
    .out_valid(out_valid[3]), .out_ready(out_ready[3]), .out_sum(out_sum[3]),
    .out_cout(out_cout[3]), .out_ovf(out_ovf[3]), .out_zero(out_zero[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: exact unsigned and signed arithmetic on the effective operands.
  function automatic logic [34:0] ref_calc(input logic [31:0] a, input logic [31:0] b,
                                           input logic cin, input logic op, input logic sat);
    logic [31:0] be;
    logic [32:0] u;
    longint      s;
    logic        ovf;
    logic [31:0] sum;
    be  = op ? ~b : b;
    u   = {1'b0, a} + {1'b0, be} + {32'b0, cin};
    s   = longint'($signed(a)) + longint'($signed(be)) + longint'({63'b0, cin});
    ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    sum = u[31:0];
    if (sat && ovf) sum = (s > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
    return {sum, u[32], ovf, sum == 32'h0};
  endfunction

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Scoreboard: every accepted beat is modelled, every emitted beat is popped in order,
  // and a stalled output must hold its value.
  always @(negedge clk) begin
    for (int d = 0; d < ND; d++) begin
      logic [34:0] obs;
      obs = {out_sum[d], out_cout[d], out_ovf[d], out_zero[d]};
      if (!rst_n) begin
        exp_q[d].delete();
        held[d] = 1'b0;
      end else begin
        if (held[d]) begin
          check($sformatf("hold_valid_d%0d", d), 64'(out_valid[d]), 64'd1);
          check($sformatf("hold_data_d%0d", d), 64'(obs), 64'(held_val[d]));
        end
        if (out_valid[d] && out_ready[d]) begin
          check($sformatf("beat_expected_d%0d", d), 64'(exp_q[d].size() != 0), 64'd1);
          if (exp_q[d].size() != 0)
            check($sformatf("result_d%0d", d), 64'(obs), 64'(exp_q[d].pop_front()));
        end
        held[d]     = out_valid[d] && !out_ready[d];
        held_val[d] = obs;
        if (in_valid[d] && in_ready[d])
          exp_q[d].push_back(ref_calc(in_a[d], in_b[d], in_cin[d], in_op[d], SAT_MASK[d]));
      end
    end
  end

  task automatic set_pair(input logic v, input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic op);
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = v;
      in_a[d]     = a;
      in_b[d]     = b;
      in_cin[d]   = cin;
      in_op[d]    = op;
    end
  endtask

  // Sends one beat to the 4-stage pair and returns at the negedge where out_valid first appears.
  task automatic send_wait(input logic [31:0] a, input logic [31:0] b,
                           input logic cin, input logic op, output int l);
    @(posedge clk); #1;
    set_pair(1'b1, a, b, cin, op);
    @(negedge clk);
    check("accept_ready", 64'(in_ready[0]), 64'd1);
    @(posedge clk); #1;
    set_pair(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    l = 1;
    @(negedge clk);
    while (!out_valid[0] && l < 10) begin
      @(negedge clk);
      l++;
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < ND; d++) begin
      in_valid[d]  = 1'b0;
      in_a[d]      = '0;
      in_b[d]      = '0;
      in_cin[d]    = 1'b0;
      in_op[d]     = 1'b0;
      out_ready[d] = 1'b1;
    end

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready[0]), 64'd0);
    check("rst_out_valid", 64'(out_valid[0]), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready[0]), 64'd1);
    check("post_rst_out_valid", 64'(out_valid[0]), 64'd0);
    check("post_rst_out_sum", 64'(out_sum[0]), 64'd0);
    check("post_rst_out_zero", 64'(out_zero[0]), 64'd0);

    // 1 + 0xFFFF_FFFF wraps to zero with carry
    send_wait(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, lat);
    check("t1_latency", 64'(lat), 64'd4);
    check("t1_sum", 64'(out_sum[0]), 64'h0);
    check("t1_cout", 64'(out_cout[0]), 64'd1);
    check("t1_ovf", 64'(out_ovf[0]), 64'd0);
    check("t1_zero", 64'(out_zero[0]), 64'd1);

    // 5 - 7 borrows, 7 - 5 does not
    send_wait(32'd5, 32'd7, 1'b1, 1'b1, lat);
    check("t2a_sum", 64'(out_sum[0]), 64'hFFFF_FFFE);
    check("t2a_cout", 64'(out_cout[0]), 64'd0);
    check("t2a_ovf", 64'(out_ovf[0]), 64'd0);
    check("t2a_zero", 64'(out_zero[0]), 64'd0);
    send_wait(32'd7, 32'd5, 1'b1, 1'b1, lat);
    check("t2b_sum", 64'(out_sum[0]), 64'd2);
    check("t2b_cout", 64'(out_cout[0]), 64'd1);

    // Signed overflow: wrap on d0, saturate on d1
    send_wait(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, lat);
    check("t3a_wrap_sum", 64'(out_sum[0]), 64'h8000_0000);
    check("t3a_wrap_ovf", 64'(out_ovf[0]), 64'd1);
    check("t3a_sat_sum", 64'(out_sum[1]), 64'h7FFF_FFFF);
    check("t3a_sat_ovf", 64'(out_ovf[1]), 64'd1);
    send_wait(32'h8000_0000, 32'h1, 1'b1, 1'b1, lat);
    check("t3b_sat_sum", 64'(out_sum[1]), 64'h8000_0000);
    check("t3b_sat_ovf", 64'(out_ovf[1]), 64'd1);
    check("t3b_sat_cout", 64'(out_cout[1]), 64'd1);
    check("t3b_wrap_sum", 64'(out_sum[0]), 64'h7FFF_FFFF);

    // Back-to-back beats against a stalled consumer, then release
    bi = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      out_ready[0] = 1'b0;
      out_ready[1] = 1'b0;
      set_pair(bi < 8, 32'(bi), 32'(bi), 1'b0, 1'b0);
      @(negedge clk);
      if (in_valid[0] && in_ready[0]) bi++;
    end
    check("t4_held_beats", 64'(bi), 64'd4);
    check("t4_full_in_ready", 64'(in_ready[0]), 64'd0);
    check("t4_full_out_valid", 64'(out_valid[0]), 64'd1);
    ng = 0;
    for (int c = 0; c < 20 && ng < 8; c++) begin
      @(posedge clk); #1;
      out_ready[0] = 1'b1;
      out_ready[1] = 1'b1;
      set_pair(bi < 8, 32'(bi), 32'(bi), 1'b0, 1'b0);
      @(negedge clk);
      if (c == 0) check("t4_accept_with_emit", 64'(in_ready[0]), 64'd1);
      if (in_valid[0] && in_ready[0]) bi++;
      if (out_valid[0] && out_ready[0]) begin
        got[ng]  = out_sum[0];
        gcyc[ng] = c;
        ng++;
      end
    end
    check("t4_out_count", 64'(ng), 64'd8);
    if (ng == 8) begin
      check("t4_no_gaps", 64'(gcyc[7] - gcyc[0]), 64'd7);
      for (int j = 0; j < 8; j++) check($sformatf("t4_order_%0d", j), 64'(got[j]), 64'(2 * j));
    end
    @(posedge clk); #1;
    set_pair(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (6) @(posedge clk);
    #1;

    // Reset with three beats in flight
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      set_pair(1'b1, 32'(100 + i), 32'd1, 1'b0, 1'b0);
      @(negedge clk);
      check($sformatf("t5_accept_%0d", i), 64'(in_ready[0]), 64'd1);
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    set_pair(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    check("t5_rst_in_ready", 64'(in_ready[0]), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    set_pair(1'b1, 32'd500, 32'd5, 1'b0, 1'b0);
    @(negedge clk);
    check("t5_out_valid_cleared", 64'(out_valid[0]), 64'd0);
    check("t5_accept_after_rst", 64'(in_ready[0]), 64'd1);
    @(posedge clk); #1;
    set_pair(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    n_out = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid[0]) begin
        n_out++;
        check("t5_new_sum", 64'(out_sum[0]), 64'd505);
      end
      @(posedge clk); #1;
    end
    check("t5_out_count", 64'(n_out), 64'd1);

    // Randomized traffic on all four configurations
    for (int d = 0; d < ND; d++) begin
      cnt[d]      = 0;
      took[d]     = 1'b0;
      in_valid[d] = 1'b0;
    end
    cyc = 0;
    while ((cnt[0] < NB || cnt[1] < NB || cnt[2] < NB || cnt[3] < NB) && cyc < 40000) begin
      @(posedge clk); #1;
      for (int d = 0; d < ND; d++) begin
        if (!in_valid[d] || took[d]) begin
          in_valid[d] = (cnt[d] < NB) && ($urandom_range(3) != 0);
          in_a[d]     = rnd_opnd();
          in_b[d]     = rnd_opnd();
          in_cin[d]   = 1'($urandom_range(1));
          in_op[d]    = 1'($urandom_range(1));
        end
        out_ready[d] = ($urandom_range(3) != 0);
      end
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
        took[d] = in_valid[d] && in_ready[d];
        if (took[d]) cnt[d]++;
      end
      cyc++;
    end
    check("rand_cycle_budget", 64'(cyc < 40000), 64'd1);

    @(posedge clk); #1;
    for (int d = 0; d < ND; d++) begin
      in_valid[d]  = 1'b0;
      out_ready[d] = 1'b1;
    end
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (exp_q[0].size() == 0 && exp_q[1].size() == 0 &&
          exp_q[2].size() == 0 && exp_q[3].size() == 0) break;
    end
    for (int d = 0; d < ND; d++) begin
      check($sformatf("drain_empty_d%0d", d), 64'(exp_q[d].size()), 64'd0);
      check($sformatf("beats_sent_d%0d", d), 64'(cnt[d]), 64'(NB));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
